// File: rtl/cv32e40p_div_seq.sv
// ----------------------------------------------------------------------------
// cv32e40p_div_seq
// Iterative radix-2 restoring divider for the EX stage. It computes
// DIVU/DIV/REMU/REM over WIDTH-bit operands and produces one quotient bit
// per cycle. Operands are captured on accept, so the ID/EX inputs may change
// while a division runs.
//
// Handshake: enable_i requests a start and is only looked at in IDLE.
// ready_o is 1 in IDLE when no start is requested, 0 while a division is
// pending or running, and 1 in FINISH. The result is held in FINISH until
// the EX stage takes it with ex_ready_i=1. The FSM then returns to IDLE, and
// the next accept can happen one cycle later at the earliest.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable_i        start request (sampled in IDLE only)
//   operator_i      00 DIVU, 01 DIV, 10 REMU, 11 REM
//   op_a_i, op_b_i  dividend, divisor
//   result_o        quotient/remainder, valid in FINISH, otherwise 0
//   multicycle_o    high while dividing
//   ready_o         see handshake above
//   ex_ready_i      EX consumes the result (leaves FINISH)
//   debug_state_o   current FSM state (0 IDLE, 1 DIVIDE, 2 FINISH)
// ----------------------------------------------------------------------------
module cv32e40p_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             multicycle_o,
  output logic             ready_o,
  input  logic             ex_ready_i,
  output logic [1:0]       debug_state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               rem_sel_q, rem_sel_d;   // operator bit1: remainder
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   b_abs_q, b_abs_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;     // raw dividend for the div-by-0 remainder
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Two's-complement negate in WIDTH bits. The most negative value maps to
  // itself, which reads as 2^(WIDTH-1) when treated as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    neg = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic             in_sign_a, in_sign_b;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign in_sign_a = operator_i[0] & op_a_i[WIDTH-1];
  assign in_sign_b = operator_i[0] & op_b_i[WIDTH-1];

  // Restoring step. rem_q is always below |b|, so the top bit of shifted is
  // 0 in practice. The subtract is done two bits wider than |b| so that
  // trial[WIDTH+1] is a clean borrow/sign bit.
  assign shifted = {rem_q, q_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, b_abs_q};

  // Sign fix-up. It is combinational and only used in FINISH, so it stays out
  // of the per-step critical path.
  assign quot_fix = div0_q ? {WIDTH{1'b1}}
                           : ((sign_a_q ^ sign_b_q) ? neg(q_q) : q_q);
  assign rem_fix  = div0_q ? a_orig_q
                           : (sign_a_q ? neg(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0]);

  always_comb begin
    state_d      = state_q;
    rem_sel_d    = rem_sel_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    div0_d       = div0_q;
    b_abs_d      = b_abs_q;
    a_orig_d     = a_orig_q;
    rem_d        = rem_q;
    q_d          = q_q;
    cnt_d        = cnt_q;
    ready_o      = 1'b0;
    multicycle_o = 1'b0;
    result_o     = '0;

    unique case (state_q)
      IDLE: begin
        ready_o = ~enable_i;
        if (enable_i) begin
          rem_sel_d = operator_i[1];
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          b_abs_d   = in_sign_b ? neg(op_b_i) : op_b_i;
          q_d       = in_sign_a ? neg(op_a_i) : op_a_i;
          a_orig_d  = op_a_i;
          rem_d     = '0;
          cnt_d     = '0;
          div0_d    = (op_b_i == '0);
          state_d   = (op_b_i == '0) ? FINISH : DIVIDE;
        end
      end

      DIVIDE: begin
        multicycle_o = 1'b1;
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        ready_o  = 1'b1;
        result_o = rem_sel_q ? rem_fix : quot_fix;
        if (ex_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_sel_q <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      div0_q    <= 1'b0;
      b_abs_q   <= '0;
      a_orig_q  <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      div0_q    <= div0_d;
      b_abs_q   <= b_abs_d;
      a_orig_q  <= a_orig_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
    end
  end

  assign debug_state_o = state_q;

endmodule

// File: tb/tb_cv32e40p_div_seq.sv
module tb_cv32e40p_div_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         enable_i;
  logic [1:0]   operator_i;
  logic [W-1:0] op_a_i;
  logic [W-1:0] op_b_i;
  logic [W-1:0] result_o;
  logic         multicycle_o;
  logic         ready_o;
  logic         ex_ready_i;
  logic [1:0]   debug_state_o;

  int tests;
  int fails;

  cv32e40p_div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .operator_i   (operator_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .result_o     (result_o),
    .multicycle_o (multicycle_o),
    .ready_o      (ready_o),
    .ex_ready_i   (ex_ready_i),
    .debug_state_o(debug_state_o)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;   // posedges from accept until ready_o=1
    int           mc;    // cycles with multicycle_o=1
  } vec_t;

  localparam logic [1:0] DIVU = 2'b00, DIV = 2'b01, REMU = 2'b10, REM = 2'b11;

  vec_t vecs[15];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Accepts one operation, waits for ready_o and returns the result.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output int mc);
    operator_i = op;
    op_a_i     = a;
    op_b_i     = b;
    enable_i   = 1'b1;
    #1;
    check("ready_low_on_request", {31'b0, ready_o}, 32'd0);
    @(posedge clk); #1;
    enable_i = 1'b0;
    op_a_i   = $urandom;
    op_b_i   = $urandom;
    lat = 1;
    mc  = 0;
    while (!ready_o && lat < 60) begin
      if (multicycle_o) mc++;
      @(posedge clk); #1;
      lat++;
    end
    if (multicycle_o) mc++;
    res = result_o;
  endtask

  task automatic consume();
    ex_ready_i = 1'b1;
    @(posedge clk); #1;
    ex_ready_i = 1'b0;
    check("state_idle_after_ex_ready", {30'b0, debug_state_o}, 32'd0);
    check("result_zero_in_idle", result_o, 32'd0);
    check("ready_high_in_idle", {31'b0, ready_o}, 32'd1);
  endtask

  logic [W-1:0] res;
  logic [W-1:0] held;
  int lat, mc;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         33, 32};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          33, 32};
    vecs[2]  = '{DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33, 32};
    vecs[3]  = '{REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33, 32};
    vecs[4]  = '{REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33, 32};
    vecs[5]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33, 32};
    vecs[6]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          33, 32};
    vecs[7]  = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33, 32};
    vecs[8]  = '{REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33, 32};
    vecs[9]  = '{DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  0};
    vecs[10] = '{REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1,  0};
    vecs[11] = '{DIV,  32'd20,         32'hFFFFFFFD,   32'hFFFFFFFA,   33, 32};
    vecs[12] = '{REM,  32'd20,         32'hFFFFFFFD,   32'd2,          33, 32};
    vecs[13] = '{DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, 32};
    vecs[14] = '{REMU, 32'hFFFFFFFF,   32'h10,         32'h0000000F,   33, 32};

    rst_n      = 1'b0;
    enable_i   = 1'b0;
    operator_i = 2'b00;
    op_a_i     = '0;
    op_b_i     = '0;
    ex_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result_o, 32'd0);
    check("reset_multicycle", {31'b0, multicycle_o}, 32'd0);
    check("reset_ready", {31'b0, ready_o}, 32'd1);
    check("reset_state", {30'b0, debug_state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, mc);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_multicycle_cycles", i), mc, vecs[i].mc);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      consume();
    end

    // backpressure: result held while ex_ready_i=0 and inputs wiggle
    run_op(DIVU, 32'd1000, 32'd10, res, lat, mc);
    check("bp_result", res, 32'd100);
    held = result_o;
    for (int c = 0; c < 10; c++) begin
      op_a_i     = $urandom;
      op_b_i     = $urandom;
      operator_i = 2'($urandom_range(0, 3));
      enable_i   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check($sformatf("bp_hold_result_%0d", c), result_o, 32'd100);
      check($sformatf("bp_hold_ready_%0d", c), {31'b0, ready_o}, 32'd1);
    end
    check("bp_held_vs_first", result_o, held);
    enable_i = 1'b0;
    consume();
    run_op(DIVU, 32'd81, 32'd9, res, lat, mc);
    check("bp_next_accept", res, 32'd9);
    consume();

    // reset in the middle of a division
    operator_i = DIVU;
    op_a_i     = 32'd12345;
    op_b_i     = 32'd7;
    enable_i   = 1'b1;
    @(posedge clk); #1;
    enable_i = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_reset_multicycle", {31'b0, multicycle_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_result", result_o, 32'd0);
    check("mid_reset_multicycle", {31'b0, multicycle_o}, 32'd0);
    check("mid_reset_ready", {31'b0, ready_o}, 32'd1);
    check("mid_reset_state", {30'b0, debug_state_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(DIVU, 32'd9, 32'd3, res, lat, mc);
    check("post_reset_latency", lat, 33);
    check("post_reset_result", res, 32'd3);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cv32e40p_div_seq.md
# cv32e40p_div_seq

Iterative radix-2 integer divider for the EX stage, the inverse of the MAC/MULH multiplier. It computes RISC-V DIV/DIVU/REM/REMU over WIDTH-bit operands at one quotient bit per cycle. It uses the same enable / ready / ex_ready handshake as the multiplier, so the EX stage stalls on it in the same way. Operands are captured on accept, so ID/EX may change them while the division runs.

## Interface
- WIDTH, 32: operand and result width; must be a power of two, at least 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable_i  in  1  start request; sampled only in IDLE.
- operator_i  in  2  00 DIVU, 01 DIV, 10 REMU, 11 REM; bit0 = signed, bit1 = remainder.
- op_a_i  in  WIDTH  dividend.
- op_b_i  in  WIDTH  divisor.
- result_o  out  WIDTH  quotient or remainder; valid only while in FINISH, otherwise 0.
- multicycle_o  out  1  high while in DIVIDE.
- ready_o  out  1  combinational.
  - 1 in IDLE when no start is requested.
  - 0 in IDLE when a start is requested, and 0 in DIVIDE.
  - 1 in FINISH.
- ex_ready_i  in  1  EX stage consuming the result; leaves FINISH.

## Operation
- States: IDLE, DIVIDE, FINISH. Reset state is IDLE.
- IDLE, accept (enable_i=1):
  - Latch the operation from operator_i.
  - Latch sign_a = signed & op_a[MSB] and sign_b = signed & op_b[MSB].
  - Latch magnitudes |a| and |b|; a negative value is negated in WIDTH bits, so the most negative value maps to 2^(WIDTH-1), unsigned.
  - Clear the partial remainder (WIDTH+1 bits) and load the quotient register with |a|.
  - Clear the bit counter to 0.
  - If op_b_i == 0, set div0 and go to FINISH. Otherwise go to DIVIDE.
- DIVIDE, once per cycle (restoring step):
  - Form the trial value {rem, q[MSB]} - {0, |b|}.
  - If the trial value is non-negative, rem = trial value and the shifted-in quotient bit is 1.
  - If it is negative, rem = {rem, q[MSB]} and the shifted-in bit is 0.
  - Shift q left by one, inserting the new bit.
  - Increment the counter. After WIDTH steps (counter == WIDTH-1 at the edge), go to FINISH.
- FINISH, combinational fix-up, stable while held:
  - Quotient: if div0, all ones. Otherwise q, negated if sign_a XOR sign_b.
  - Remainder: if div0, the latched original dividend. Otherwise rem[WIDTH-1:0], negated if sign_a.
  - Overflow case (DIV of most-negative by -1) falls out naturally: quotient 0x80..0, remainder 0. It has no special path.
  - Stay in FINISH until ex_ready_i=1, then go to IDLE. There is no back-to-back accept in that same cycle.
- enable_i and operand changes outside IDLE are ignored.
- Reset asserted in any state clears all registers and returns to IDLE. No partial result is produced.

## Timing
- Reset values:
  - state = IDLE, result_o = 0, multicycle_o = 0.
  - ready_o = 1 while enable_i = 0.
  - All datapath registers 0.
- Normal latency: accept in cycle 0, DIVIDE in cycles 1..WIDTH, FINISH from cycle WIDTH+1. For WIDTH=32 that is 33 cycles from accept to ready_o=1.
- Divide by zero: FINISH at cycle 1.
- Result and ready_o stay stable in FINISH for any number of cycles while ex_ready_i=0.
- Next accept is possible at the earliest one cycle after the ex_ready_i cycle.
- Critical path: one WIDTH+1-bit subtract plus mux per cycle. The final negate is in FINISH only.

## Test plan
- DIVU 100 / 7: ready_o low for 32 cycles after accept, multicycle_o high in cycles 1..32; cycle 33 result_o = 14 and ready_o = 1. Same operands with REMU give 2.
- DIV -7 / 2 gives 0xFFFFFFFD (-3). REM -7 / 2 gives 0xFFFFFFFF (-1). REM 7 / -2 gives 1.
- DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0. DIVU with the same operands gives 0 and REMU gives 0x80000000.
- DIVU 5 / 0 gives 0xFFFFFFFF and REM -5 / 0 gives 0xFFFFFFFB, both with ready_o = 1 at cycle 1 and multicycle_o never high.
- Backpressure: hold ex_ready_i = 0 for 10 cycles in FINISH while changing op_a_i, op_b_i and enable_i. result_o stays constant. After ex_ready_i pulses, the state is IDLE and a new accept works.
- Reset: assert rst_n low mid-DIVIDE (cycle 10). Outputs take their reset values immediately. After release, a fresh DIVU 9 / 3 gives 3.
